nw_cell_engine: RTL and testbench

Computes one Needleman-Wunsch matrix cell. It fetches the diagonal, up and left neighbour scores from the score RAM, adds the substitution and gap terms, and selects the maximum. It writes the result back to the score RAM and reports the traceback direction. It sits directly downstream of the 3-step neighbour-fetch counter in score RAM management: it consumes one neighbour per step and produces the cell result for the traceback stage.

---
 rtl/nw_cell_engine_pkg.sv | 40 ++++
 rtl/nw_cell_engine_if.sv | 21 ++
 rtl/nw_cell_engine_max3.sv | 41 ++++
 rtl/nw_cell_engine.sv | 143 ++++++++++++++
 tb/tb_nw_cell_engine.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/nw_cell_engine_pkg.sv
// Shared constants, encodings and address helper for the Needleman-Wunsch cell engine.
package nw_cell_engine_pkg;

    localparam int N        = 8;
    localparam int SCORE_W  = 8;
    localparam int ADDR_W   = 7;
    localparam int MATCH    = 1;
    localparam int MISMATCH = -1;
    localparam int GAP      = -1;
    localparam int IDX_W    = $clog2(N + 1);

    typedef enum logic [1:0] {
        DIR_DIAG = 2'b00,
        DIR_UP   = 2'b01,
        DIR_LEFT = 2'b10
    } dir_e;

    typedef enum logic [1:0] {
        NT_A = 2'b00,
        NT_C = 2'b01,
        NT_G = 2'b10,
        NT_T = 2'b11
    } nt_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_DIAG,
        S_RD_UP,
        S_RD_LEFT,
        S_CALC,
        S_WRITE,
        S_DONE
    } state_e;

    // Row-major score matrix address of cell (i, j) in an (N+1)x(N+1) matrix.
    function automatic logic [ADDR_W-1:0] addr(input int i, input int j);
        return ADDR_W'(i * (N + 1) + j);
    endfunction

endpackage

// File: rtl/nw_cell_engine_if.sv
// Score RAM port bundle: the engine is the master, the RAM is the slave.
interface nw_cell_engine_if;
    import nw_cell_engine_pkg::*;

    logic [ADDR_W-1:0]         ram_addr;
    logic                      ram_re;
    logic signed [SCORE_W-1:0] ram_rdata;
    logic                      ram_we;
    logic signed [SCORE_W-1:0] ram_wdata;

    modport master (
        output ram_addr, ram_re, ram_we, ram_wdata,
        input  ram_rdata
    );

    modport slave (
        input  ram_addr, ram_re, ram_we, ram_wdata,
        output ram_rdata
    );

endinterface

// File: rtl/nw_cell_engine_max3.sv
// Three-way max over widened candidates with diag > up > left tie priority,
// saturated back to the score width.
module nw_max3
    import nw_cell_engine_pkg::*;
(
    input  logic signed [SCORE_W:0]   cd,
    input  logic signed [SCORE_W:0]   cu,
    input  logic signed [SCORE_W:0]   cl,
    output logic signed [SCORE_W-1:0] max_out,
    output dir_e                      dir
);

    localparam logic signed [SCORE_W:0] SAT_HI = (SCORE_W + 1)'((2 ** (SCORE_W - 1)) - 1);
    localparam logic signed [SCORE_W:0] SAT_LO = (SCORE_W + 1)'(-(2 ** (SCORE_W - 1)));

    logic signed [SCORE_W:0] best;

    // Pick the winner (strict > keeps the earlier candidate on ties), then clamp.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        best    = cd;
        dir     = DIR_DIAG;
        max_out = '0;
        if (cu > best) begin
            best = cu;
            dir  = DIR_UP;
        end
        if (cl > best) begin
            best = cl;
            dir  = DIR_LEFT;
        end
        if (best > SAT_HI) begin
            max_out = SAT_HI[SCORE_W-1:0];
        end else if (best < SAT_LO) begin
            max_out = SAT_LO[SCORE_W-1:0];
        end else begin
            max_out = best[SCORE_W-1:0];
        end
    end

endmodule

// File: rtl/nw_cell_engine.sv
// Needleman-Wunsch single-cell engine: reads diag/up/left neighbours from the
// score RAM, picks the best candidate, writes it back and reports direction.
module nw_cell_engine
    import nw_cell_engine_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [IDX_W-1:0]          i_idx,
    input  logic [IDX_W-1:0]          j_idx,
    input  logic [1:0]                sym_a,
    input  logic [1:0]                sym_b,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic signed [SCORE_W-1:0] score_out,
    output logic [1:0]                dir_out,
    nw_cell_engine_if.master          ram
);

    localparam logic signed [SCORE_W:0] SUB_MATCH    = (SCORE_W + 1)'(MATCH);
    localparam logic signed [SCORE_W:0] SUB_MISMATCH = (SCORE_W + 1)'(MISMATCH);
    localparam logic signed [SCORE_W:0] GAP_EXT      = (SCORE_W + 1)'(GAP);

    state_e                    state;
    logic [IDX_W-1:0]          i_q, j_q;
    nt_e                       sym_a_q, sym_b_q;
    logic signed [SCORE_W-1:0] diag_q, up_q;
    logic [ADDR_W-1:0]         addr_q;
    logic                      re_q, we_q;
    logic signed [SCORE_W-1:0] wdata_q;

    logic signed [SCORE_W:0]   sub, cd, cu, cl;
    logic signed [SCORE_W-1:0] max_val;
    dir_e                      max_dir;
    logic                      idx_ok;

    // Candidates are formed one bit wider so the saturating max sees true overflow;
    // the left neighbour is used straight off the RAM read port during CALC.
    assign sub = (sym_a_q == sym_b_q) ? SUB_MATCH : SUB_MISMATCH;
    assign cd  = {diag_q[SCORE_W-1], diag_q} + sub;
    assign cu  = {up_q[SCORE_W-1], up_q} + GAP_EXT;
    assign cl  = {ram.ram_rdata[SCORE_W-1], ram.ram_rdata} + GAP_EXT;

    assign idx_ok = (i_idx != '0) && (int'(i_idx) <= N) &&
                    (j_idx != '0) && (int'(j_idx) <= N);

    nw_max3 u_max3 (
        .cd      (cd),
        .cu      (cu),
        .cl      (cl),
        .max_out (max_val),
        .dir     (max_dir)
    );

    assign ram.ram_addr  = addr_q;
    assign ram.ram_re    = re_q;
    assign ram.ram_we    = we_q;
    assign ram.ram_wdata = wdata_q;

    // Cell FSM; every output is registered alongside the state it belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            re_q      <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            score_out <= '0;
            dir_out   <= DIR_DIAG;
            i_q       <= '0;
            j_q       <= '0;
            sym_a_q   <= NT_A;
            sym_b_q   <= NT_A;
            diag_q    <= '0;
            up_q      <= '0;
        end else begin
            // NOTE: non-blocking throughout so every branch sees pre-edge state.
            done   <= 1'b0;
            err    <= 1'b0;
            re_q   <= 1'b0;
            we_q   <= 1'b0;
            addr_q <= '0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (idx_ok) begin
                            i_q     <= i_idx;
                            j_q     <= j_idx;
                            sym_a_q <= nt_e'(sym_a);
                            sym_b_q <= nt_e'(sym_b);
                            busy    <= 1'b1;
                            re_q    <= 1'b1;
                            addr_q  <= addr(int'(i_idx) - 1, int'(j_idx) - 1);
                            state   <= S_RD_DIAG;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_RD_DIAG: begin
                    re_q   <= 1'b1;
                    addr_q <= addr(int'(i_q) - 1, int'(j_q));
                    state  <= S_RD_UP;
                end
                S_RD_UP: begin
                    diag_q <= ram.ram_rdata;
                    re_q   <= 1'b1;
                    addr_q <= addr(int'(i_q), int'(j_q) - 1);
                    state  <= S_RD_LEFT;
                end
                S_RD_LEFT: begin
                    up_q  <= ram.ram_rdata;
                    state <= S_CALC;
                end
                S_CALC: begin
                    we_q      <= 1'b1;
                    addr_q    <= addr(int'(i_q), int'(j_q));
                    wdata_q   <= max_val;
                    score_out <= max_val;
                    dir_out   <= max_dir;
                    state     <= S_WRITE;
                end
                S_WRITE: begin
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nw_cell_engine.sv
// Directed bench for nw_cell_engine with a one-cycle-latency score RAM model.
module tb_nw_cell_engine;
    import nw_cell_engine_pkg::*;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      start = 1'b0;
    logic [IDX_W-1:0]          i_idx = '0;
    logic [IDX_W-1:0]          j_idx = '0;
    logic [1:0]                sym_a = '0;
    logic [1:0]                sym_b = '0;
    logic                      busy, done, err;
    logic signed [SCORE_W-1:0] score_out;
    logic [1:0]                dir_out;

    logic signed [SCORE_W-1:0] mem [0:(1 << ADDR_W) - 1];

    int checks = 0;
    int errors = 0;

    nw_cell_engine_if ram_bus ();

    nw_cell_engine dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .i_idx     (i_idx),
        .j_idx     (j_idx),
        .sym_a     (sym_a),
        .sym_b     (sym_b),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .score_out (score_out),
        .dir_out   (dir_out),
        .ram       (ram_bus.master)
    );

    always #5 clk = ~clk;

    // Score RAM read port: data for an enabled read appears the following cycle.
    always @(posedge clk) begin
        if (ram_bus.ram_re) ram_bus.ram_rdata <= mem[ram_bus.ram_addr];
    end

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Run one cell for a fixed 12-cycle window, logging per-cycle activity.
    task automatic run_cell(input string tag, input int i, input int j,
                            input int a, input int b, input bit poke,
                            input int exp_rd0, input int exp_rd1, input int exp_rd2,
                            input int exp_wa, input int exp_score, input int exp_dir);
        int re_mask = 0, we_mask = 0, busy_mask = 0;
        int done_n = 0, done_cnt = 0, err_cnt = 0;
        int ra [1:3];
        int wa = -1;
        logic signed [SCORE_W-1:0] wd = '0;
        ra = '{-1, -1, -1};
        @(negedge clk);
        start = 1'b1;
        i_idx = IDX_W'(i);
        j_idx = IDX_W'(j);
        sym_a = 2'(a);
        sym_b = 2'(b);
        @(posedge clk);
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            if (poke && n == 2) start = 1'b1;
            if (poke && n == 3) start = 1'b0;
            if (ram_bus.ram_re) begin
                re_mask |= (1 << n);
                if (n <= 3) ra[n] = int'(ram_bus.ram_addr);
            end
            if (ram_bus.ram_we) begin
                we_mask |= (1 << n);
                wa = int'(ram_bus.ram_addr);
                wd = ram_bus.ram_wdata;
            end
            if (done) begin
                done_cnt++;
                if (done_n == 0) done_n = n;
            end
            if (err) err_cnt++;
            if (busy) busy_mask |= (1 << n);
        end
        check({tag, ".re_cycles"}, re_mask, 32'sb1110);
        check({tag, ".rd_diag"}, ra[1], exp_rd0);
        check({tag, ".rd_up"}, ra[2], exp_rd1);
        check({tag, ".rd_left"}, ra[3], exp_rd2);
        check({tag, ".we_cycles"}, we_mask, 32'sb100000);
        check({tag, ".wr_addr"}, wa, exp_wa);
        check({tag, ".wr_data"}, wd, exp_score);
        check({tag, ".score"}, score_out, exp_score);
        check({tag, ".dir"}, dir_out, exp_dir);
        check({tag, ".done_latency"}, done_n, 6);
        check({tag, ".done_count"}, done_cnt, 1);
        check({tag, ".busy_cycles"}, busy_mask, 32'sb1111110);
        check({tag, ".no_err"}, err_cnt, 0);
    endtask

    // Issue an out-of-range start and confirm a lone err pulse with no RAM access.
    task automatic reject(input string tag, input int i, input int j);
        @(negedge clk);
        start = 1'b1;
        i_idx = IDX_W'(i);
        j_idx = IDX_W'(j);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check({tag, ".err"}, err, 1);
        check({tag, ".re"}, ram_bus.ram_re, 0);
        check({tag, ".busy"}, busy, 0);
        @(negedge clk);
        check({tag, ".err_pulse"}, err, 0);
        check({tag, ".busy_after"}, busy, 0);
        check({tag, ".re_after"}, ram_bus.ram_re, 0);
    endtask

    initial begin
        int we_seen;
        for (int k = 0; k < (1 << ADDR_W); k++) mem[k] = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.err", err, 0);
        check("rst.re", ram_bus.ram_re, 0);
        check("rst.we", ram_bus.ram_we, 0);
        check("rst.addr", ram_bus.ram_addr, 0);
        check("rst.wdata", ram_bus.ram_wdata, 0);
        check("rst.score", score_out, 0);
        check("rst.dir", dir_out, 0);
        rst = 1'b0;

        // Match at (1,1): cd=1, cu=-2, cl=-2
        mem[0] = 8'sd0; mem[1] = -8'sd1; mem[9] = -8'sd1;
        run_cell("match11", 1, 1, 2, 2, 1'b0, 0, 1, 9, 10, 1, 0);

        // Diag/up tie at (2,3), mismatch: cd=-1, cu=-1, cl=-4
        mem[11] = 8'sd0; mem[12] = 8'sd0; mem[20] = -8'sd3;
        run_cell("tie23", 2, 3, 0, 1, 1'b0, 11, 12, 20, 21, -1, 0);

        // Left wins at (8,8), mismatch: cd=-6, cu=-7, cl=1
        mem[70] = -8'sd5; mem[71] = -8'sd6; mem[79] = 8'sd2;
        run_cell("left88", 8, 8, 1, 3, 1'b0, 70, 71, 79, 80, 1, 2);

        // Up beats left on a tie at (4,5), mismatch: cd=-1, cu=4, cl=4
        mem[31] = 8'sd0; mem[32] = 8'sd5; mem[40] = 8'sd5;
        run_cell("up45", 4, 5, 2, 3, 1'b0, 31, 32, 40, 41, 4, 1);

        // Saturate high at (1,2): diag=127 plus match
        mem[1] = 8'sd127; mem[2] = 8'sd0; mem[10] = 8'sd0;
        run_cell("sat_hi", 1, 2, 3, 3, 1'b0, 1, 2, 10, 11, 127, 0);

        // Saturate low at (3,1): all -128, mismatch -> -129 everywhere
        mem[18] = -8'sd128; mem[19] = -8'sd128; mem[27] = -8'sd128;
        run_cell("sat_lo", 3, 1, 0, 2, 1'b0, 18, 19, 27, 28, -128, 0);

        // Out-of-range starts
        reject("rej_i0", 0, 1);
        reject("rej_j9", 1, 9);

        // Start re-asserted during RD_UP must be ignored
        mem[0] = 8'sd0; mem[1] = -8'sd1; mem[9] = -8'sd1;
        run_cell("poke", 1, 1, 1, 1, 1'b1, 0, 1, 9, 10, 1, 0);

        // Reset during CALC: no write, outputs back to reset values
        mem[10] = 8'sd20; mem[11] = 8'sd20; mem[19] = 8'sd20;
        we_seen = 0;
        @(negedge clk);
        start = 1'b1;
        i_idx = IDX_W'(2);
        j_idx = IDX_W'(2);
        sym_a = 2'd0;
        sym_b = 2'd0;
        @(posedge clk);
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            if (ram_bus.ram_we) we_seen++;
        end
        rst = 1'b1;
        @(negedge clk);
        if (ram_bus.ram_we) we_seen++;
        check("abort.busy", busy, 0);
        check("abort.we", ram_bus.ram_we, 0);
        check("abort.done", done, 0);
        check("abort.addr", ram_bus.ram_addr, 0);
        check("abort.score", score_out, 0);
        rst = 1'b0;
        @(negedge clk);
        if (ram_bus.ram_we) we_seen++;
        check("abort.no_write", we_seen, 0);
        check("abort.idle_busy", busy, 0);

        // Fresh start after the abort completes normally
        mem[0] = 8'sd0; mem[1] = -8'sd1; mem[9] = -8'sd1;
        run_cell("after_abort", 1, 1, 2, 2, 1'b0, 0, 1, 9, 10, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
